// File: rtl/sysver_reader_if.sv
// sysver_reader_if
// Read-only AXI4-lite bundle (AR + R channels) between the system version reader
// and the systemversion slave.
// Parameters: AW address width, DW data width.
// Modports:
//   master - drives araddr/arprot/arvalid/rready, samples arready/rdata/rresp/rvalid
//   slave  - the opposite directions
interface sysver_reader_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/sysver_reader.sv
// sysver_reader
// AXI4-lite read-only initiator that fetches FPGA_VER (base+0x0) and BOARD (base+0x4)
// from the systemversion slave after reset and on each start pulse taken while idle.
// The values are held on plain outputs until the next sequence starts.
// Optional feature macro: SYSVER_RD_TIMEOUT_EN adds a per-transaction timeout that
// aborts a hung read (arvalid/rready are dropped, err and timeout are set).
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock, asynchronous active-low reset
//   m_axi                      AR/R master port (sysver_reader_if.master)
//   start                      1-cycle pulse, re-runs the read sequence when idle
//   busy                       sequence in progress
//   ver_valid                  both reads of the last sequence returned OKAY
//   err                        last sequence ended on an error response or timeout
//   timeout                    last sequence aborted on timeout (always 0 without macro)
//   ver_mismatch               ver_valid and FPGA major version differs from expected
//   fpga_ver                   captured FPGA_VER
//   board_type, board_rev      captured BOARD[31:16], BOARD[15:0]
//
// state   | meaning
// --------+-----------------------------------------------
// BOOT    | first cycle after reset, launches the sequence
// AR0     | FPGA_VER address phase (arvalid=1)
// R0      | FPGA_VER data phase (rready=1)
// AR1     | BOARD address phase (arvalid=1)
// R1      | BOARD data phase (rready=1)
// DONE    | idle, results held, waits for start
module sysver_reader #(
    parameter int                              C_M_AXI_ADDR_WIDTH = 32,
    parameter int                              C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]   C_BASE_ADDR        = 32'h4000_0000,
    parameter logic [7:0]                      C_EXP_VER_MAJ      = 8'd0,
    parameter int                              C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    sysver_reader_if.master      m_axi,
    input  logic                 start,
    output logic                 busy,
    output logic                 ver_valid,
    output logic                 err,
    output logic                 timeout,
    output logic                 ver_mismatch,
    output logic [31:0]          fpga_ver,
    output logic [15:0]          board_type,
    output logic [15:0]          board_rev
);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_AR0  = 3'd1,
        ST_R0   = 3'd2,
        ST_AR1  = 3'd3,
        ST_R1   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rready_q, rready_d;
    logic                            ver_valid_q, ver_valid_d;
    logic                            err_q, err_d;
    logic                            timeout_q, timeout_d;
    logic [31:0]                     fpga_ver_q, fpga_ver_d;
    logic [15:0]                     board_type_q, board_type_d;
    logic [15:0]                     board_rev_q, board_rev_d;

    logic [C_M_AXI_DATA_WIDTH-1:0]   rdata;
    logic                            ar_hs;
    logic                            r_hs;
    logic                            tmo_hit;

    assign rdata = m_axi.rdata;
    assign ar_hs = arvalid_q && m_axi.arready;
    assign r_hs  = rready_q && m_axi.rvalid;

`ifdef SYSVER_RD_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(C_TIMEOUT_CYCLES - 1);

    logic [15:0] tcnt_q, tcnt_d;

    // Restarts on every state change, so each AR/R phase gets its own budget.
    always_comb begin
        tcnt_d = tcnt_q;
        if (state_d != state_q) begin
            tcnt_d = '0;
        end else if (busy) begin
            tcnt_d = tcnt_q + 16'd1;
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    assign tmo_hit = (tcnt_q == TMO_LAST);
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^C_TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ver_valid_d  = ver_valid_q;
        err_d        = err_q;
        timeout_d    = timeout_q;
        fpga_ver_d   = fpga_ver_q;
        board_type_d = board_type_q;
        board_rev_d  = board_rev_q;

        case (state_q)
            ST_BOOT: begin
                state_d     = ST_AR0;
                ver_valid_d = 1'b0;
                err_d       = 1'b0;
                timeout_d   = 1'b0;
            end
            ST_AR0, ST_AR1: begin
                if (ar_hs) begin
                    state_d = (state_q == ST_AR0) ? ST_R0 : ST_R1;
                end else if (tmo_hit) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_R0: begin
                if (r_hs) begin
                    fpga_ver_d = rdata[31:0];
                    if (m_axi.rresp == RESP_OKAY) begin
                        state_d = ST_AR1;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_R1: begin
                if (r_hs) begin
                    board_type_d = rdata[31:16];
                    board_rev_d  = rdata[15:0];
                    state_d      = ST_DONE;
                    // Reaching R1 means the FPGA_VER read was already OKAY.
                    if (m_axi.rresp == RESP_OKAY) begin
                        ver_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d   = ST_DONE;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d     = ST_AR0;
                    ver_valid_d = 1'b0;
                    err_d       = 1'b0;
                    timeout_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Bus controls are registered from the next state so they change only on
    // state entry; araddr holds its value for the whole address phase.
    always_comb begin
        arvalid_d = (state_d == ST_AR0) || (state_d == ST_AR1);
        rready_d  = (state_d == ST_R0) || (state_d == ST_R1);
        araddr_d  = araddr_q;
        if (state_d == ST_AR0) begin
            araddr_d = C_BASE_ADDR;
        end else if (state_d == ST_AR1) begin
            araddr_d = C_BASE_ADDR + C_M_AXI_ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q      <= ST_BOOT;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            ver_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            timeout_q    <= 1'b0;
            fpga_ver_q   <= '0;
            board_type_q <= '0;
            board_rev_q  <= '0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            ver_valid_q  <= ver_valid_d;
            err_q        <= err_d;
            timeout_q    <= timeout_d;
            fpga_ver_q   <= fpga_ver_d;
            board_type_q <= board_type_d;
            board_rev_q  <= board_rev_d;
        end
    end

    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    assign busy         = (state_q == ST_AR0) || (state_q == ST_R0) ||
                          (state_q == ST_AR1) || (state_q == ST_R1);
    assign ver_valid    = ver_valid_q;
    assign err          = err_q;
    assign timeout      = timeout_q;
    assign ver_mismatch = ver_valid_q && (fpga_ver_q[31:24] != C_EXP_VER_MAJ);
    assign fpga_ver     = fpga_ver_q;
    assign board_type   = board_type_q;
    assign board_rev    = board_rev_q;

endmodule

// File: tb/tb_sysver_reader.sv
// tb_sysver_reader
// Bench for sysver_reader: AXI-lite slave model with programmable wait states,
// responses and a hang mode; table vectors, randomized sequences against a
// behavioural model, and hand-written corner sequences.
module tb_sysver_reader;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, ver_valid, err, timeout, ver_mismatch;
    logic [31:0] fpga_ver;
    logic [15:0] board_type, board_rev;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sysver_reader_if #(.AW(32), .DW(32)) bus ();

    sysver_reader #(
        .C_TIMEOUT_CYCLES(16)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_aresetn(rst_n),
        .m_axi        (bus),
        .start        (start),
        .busy         (busy),
        .ver_valid    (ver_valid),
        .err          (err),
        .timeout      (timeout),
        .ver_mismatch (ver_mismatch),
        .fpga_ver     (fpga_ver),
        .board_type   (board_type),
        .board_rev    (board_rev)
    );

    // ---------------- slave model ----------------
    logic [31:0] sl_fpga = 32'h0102_0034;
    logic [31:0] sl_board = 32'h0003_0001;
    logic [1:0]  sl_r0 = 2'b00;
    logic [1:0]  sl_r1 = 2'b00;
    int          sl_ard = 0;
    int          sl_rd = 0;
    bit          sl_hang = 1'b0;

    int          ar_cnt, r_cnt;
    bit          pend;
    logic [31:0] pend_addr;
    logic [31:0] ar_q[$];
    int          ar_viol = 0;
    logic        prev_wait;
    logic [31:0] prev_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= '0;
            ar_cnt      <= 0;
            r_cnt       <= 0;
            pend        <= 1'b0;
            pend_addr   <= '0;
            prev_wait   <= 1'b0;
            prev_addr   <= '0;
        end else begin
            prev_wait <= bus.arvalid && !bus.arready;
            prev_addr <= bus.araddr;
            if (prev_wait && (!bus.arvalid || bus.araddr != prev_addr))
                ar_viol <= ar_viol + 1;
            if (bus.arvalid && bus.arready) begin
                bus.arready <= 1'b0;
                pend        <= 1'b1;
                pend_addr   <= bus.araddr;
                ar_q.push_back(bus.araddr);
                r_cnt       <= 0;
                ar_cnt      <= 0;
            end else if (bus.arvalid && !pend && !sl_hang) begin
                if (ar_cnt >= sl_ard) bus.arready <= 1'b1;
                else ar_cnt <= ar_cnt + 1;
            end
            if (pend && !bus.rvalid) begin
                if (r_cnt >= sl_rd) begin
                    bus.rvalid <= 1'b1;
                    if (pend_addr == BASE) begin
                        bus.rdata <= sl_fpga;
                        bus.rresp <= sl_r0;
                    end else if (pend_addr == BASE + 32'd4) begin
                        bus.rdata <= sl_board;
                        bus.rresp <= sl_r1;
                    end else begin
                        bus.rdata <= 32'hDEAD_BEEF;
                        bus.rresp <= 2'b11;
                    end
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
                pend       <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        bit fin = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) chk({name, "_done_bound"}, 64'd0, 64'd1);
    endtask

    task automatic check_out(input string tag, input logic e_vv, input logic e_err,
                             input logic e_to, input logic e_mm, input logic [31:0] e_f,
                             input logic [15:0] e_bt, input logic [15:0] e_br,
                             input int n0, input int v0, input int naddr);
        int got;
        chk({tag, "_flags"}, {60'd0, ver_valid, err, timeout, ver_mismatch},
            {60'd0, e_vv, e_err, e_to, e_mm});
        chk({tag, "_fpga_ver"}, 64'(fpga_ver), 64'(e_f));
        chk({tag, "_board"}, {32'd0, board_type, board_rev}, {32'd0, e_bt, e_br});
        got = ar_q.size() - n0;
        chk({tag, "_nreads"}, 64'(got), 64'(naddr));
        for (int i = 0; i < naddr && i < got; i++)
            chk({tag, "_araddr"}, 64'(ar_q[n0 + i]), 64'(BASE + 32'(4 * i)));
        chk({tag, "_ar_stable"}, 64'(ar_viol), 64'(v0));
    endtask

    task automatic run_seq(input logic [31:0] f, input logic [31:0] b, input logic [1:0] r0,
                           input logic [1:0] r1, input int ard, input int rd,
                           output int n0, output int v0);
        sl_fpga  = f;
        sl_board = b;
        sl_r0    = r0;
        sl_r1    = r1;
        sl_ard   = ard;
        sl_rd    = rd;
        n0       = ar_q.size();
        v0       = ar_viol;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clears", {60'd0, busy, ver_valid, err, timeout}, 64'b1000);
    endtask

    typedef struct {
        logic [31:0] f;
        logic [31:0] b;
        logic [1:0]  r0;
        logic [1:0]  r1;
        int          ard;
        int          rd;
        logic        vv;
        logic        er;
        logic        mm;
        logic [15:0] bt;
        logic [15:0] br;
        int          n;
    } vec_t;

    vec_t tbl[4];

    // behavioural model state: what the outputs should hold
    logic [31:0] m_f;
    logic [15:0] m_bt, m_br;

    initial begin
        int n0, v0, bcnt;
        logic [31:0] f, b;
        logic [1:0] r0, r1;
        logic vv;

        tbl[0] = '{32'h0102_0034, 32'h0003_0001, 2'b00, 2'b00, 5, 3, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0001, 2};
        tbl[1] = '{32'h00FF_1234, 32'h00A0_0B0C, 2'b00, 2'b00, 0, 0, 1'b1, 1'b0, 1'b0, 16'h00A0, 16'h0B0C, 2};
        tbl[2] = '{32'h0200_0001, 32'h1111_2222, 2'b10, 2'b00, 1, 1, 1'b0, 1'b1, 1'b0, 16'h00A0, 16'h0B0C, 1};
        tbl[3] = '{32'h0000_0007, 32'h3333_4444, 2'b00, 2'b11, 2, 0, 1'b0, 1'b1, 1'b0, 16'h3333, 16'h4444, 2};

        // reset state
        #1 rst_n = 1'b0;
        #1;
        chk("reset_flags", {58'd0, busy, ver_valid, err, timeout, ver_mismatch, bus.arvalid},
            64'd0);
        chk("reset_regs", {fpga_ver, board_type, board_rev}, 64'd0);
        chk("reset_bus", {29'd0, bus.araddr, bus.arprot, bus.rready}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // boot sequence, zero-wait slave
        wait_done("boot");
        check_out("boot", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0102_0034, 16'h0003, 16'h0001, 0, 0, 2);

        // table vectors
        for (int i = 0; i < 4; i++) begin
            run_seq(tbl[i].f, tbl[i].b, tbl[i].r0, tbl[i].r1, tbl[i].ard, tbl[i].rd, n0, v0);
            wait_done("tbl");
            check_out($sformatf("tbl%0d", i), tbl[i].vv, tbl[i].er, 1'b0, tbl[i].mm, tbl[i].f,
                      tbl[i].bt, tbl[i].br, n0, v0, tbl[i].n);
        end
        m_f  = tbl[3].f;
        m_bt = tbl[3].bt;
        m_br = tbl[3].br;

        // randomized sequences against the model
        for (int i = 0; i < 24; i++) begin
            f = $urandom;
            if ($urandom_range(0, 2) == 0) f[31:24] = 8'h00;
            b  = $urandom;
            r0 = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
            r1 = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            run_seq(f, b, r0, r1, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), n0, v0);
            wait_done("rand");
            m_f = f;
            if (r0 == 2'b00) begin
                m_bt = b[31:16];
                m_br = b[15:0];
            end
            vv = (r0 == 2'b00) && (r1 == 2'b00);
            check_out($sformatf("rand%0d", i), vv, !vv, 1'b0, vv && (f[31:24] != 8'h00), m_f,
                      m_bt, m_br, n0, v0, (r0 == 2'b00) ? 2 : 1);
        end

        // start while busy is ignored; start in DONE gives exactly one sequence
        run_seq(32'h0500_0102, 32'h0009_0002, 2'b00, 2'b00, 3, 3, n0, v0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        check_out("busy_start", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0500_0102, 16'h0009, 16'h0002,
                  n0, v0, 2);
        repeat (10) @(negedge clk);
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        chk("no_queued_seq", 64'(ar_q.size() - n0), 64'd2);

        // reset asserted during R1
        run_seq(32'h0102_0034, 32'h0003_0001, 2'b00, 2'b00, 0, 6, n0, v0);
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.rready && bus.araddr == BASE + 32'd4) break;
            bcnt++;
            @(negedge clk);
        end
        chk("reach_r1", 64'(bcnt < 200), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_flags",
            {58'd0, busy, ver_valid, err, timeout, ver_mismatch, bus.arvalid}, 64'd0);
        chk("midreset_regs", {fpga_ver, board_type, board_rev}, 64'd0);
        chk("midreset_bus", {31'd0, bus.araddr, bus.rready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = ar_q.size();
        v0 = ar_viol;
        wait_done("reboot");
        check_out("reboot", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0102_0034, 16'h0003, 16'h0001,
                  n0, v0, 2);

        // hung slave
        sl_hang = 1'b1;
        sl_rd   = 0;
        n0      = ar_q.size();
`ifdef SYSVER_RD_TIMEOUT_EN
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            bcnt++;
            @(negedge clk);
        end
        chk("tmo_busy_cycles", 64'(bcnt), 64'd16);
        chk("tmo_flags", {59'd0, err, timeout, ver_valid, bus.arvalid, bus.rready},
            64'b11000);
        chk("tmo_nreads", 64'(ar_q.size() - n0), 64'd0);
        sl_hang = 1'b0;
`else
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("hang_waits", {61'd0, busy, timeout, bus.arvalid}, 64'b101);
        v0      = ar_viol;
        sl_hang = 1'b0;
        wait_done("hang_release");
        check_out("hang_release", 1'b1, 1'b0, 1'b0, 1'b1, 32'h0102_0034, 16'h0003, 16'h0001,
                  n0, v0, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_bound actual=expired required=finished");
        $fatal(1, "time bound");
    end
endmodule
